fp_add_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision add/subtract sequencer around the shared 24-bit mantissa adder (24+24 -> 25-bit sum).
- Unpacks operands, aligns exponents, drives one mantissa add/subtract, normalises iteratively and packs the result.
- Uses a start/busy/done handshake toward the FPU issue logic.
- Rounding is truncation toward zero; denormals flush to zero.

---
 rtl/fp_add_seq_if.sv | 14 +
 rtl/fp_add_seq.sv | 119 +++++++++++
 tb/tb_fp_add_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// fp_add_seq_if: start/busy/done handshake and operand/result bus of the FP add sequencer
interface fp_add_seq_if;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  modport master (output start, op_sub, a, b, input busy, done, result, ovf, unf);
  modport slave (input start, op_sub, a, b, output busy, done, result, ovf, unf);
endinterface

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle single-precision add/sub, truncating, denormals flushed to zero
module fp_add_seq #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8
) (
  input logic        clk,
  input logic        rst,
  fp_add_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, FINISH} state_t;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
  state_t state;
  logic [31:0] ra, rb;
  logic rsub, sx, same;
  logic [EXP_W-1:0] ex;
  logic [MAN_W-1:0] mx, my, s;
  logic [EXP_W-1:0] ea, eb, ex_n, ey_n, d;
  logic [MAN_W-2:0] fa, fb;
  logic sa, sb, a_ge, nan_a, nan_b, inf_a, inf_b, special;
  logic [MAN_W-1:0] mx_n, my_raw, my_n;
  logic [31:0] spec_res;
  logic [MAN_W:0] sum;
  // unpack captured operands, order by magnitude, align the smaller one, resolve specials
  always_comb begin
    ea = ra[30:23];
    eb = rb[30:23];
    fa = ea == '0 ? '0 : ra[22:0];
    fb = eb == '0 ? '0 : rb[22:0];
    sa = ra[31];
    sb = rb[31] ^ rsub;
    a_ge = {ea, fa} >= {eb, fb};
    ex_n = a_ge ? ea : eb;
    ey_n = a_ge ? eb : ea;
    mx_n = a_ge ? {ea != '0, fa} : {eb != '0, fb};
    my_raw = a_ge ? {eb != '0, fb} : {ea != '0, fa};
    d = ex_n - ey_n;
    my_n = d >= EXP_W'(MAN_W + 1) ? '0 : my_raw >> d;
    nan_a = ea == EMAX && ra[22:0] != '0;
    nan_b = eb == EMAX && rb[22:0] != '0;
    inf_a = ea == EMAX && ra[22:0] == '0;
    inf_b = eb == EMAX && rb[22:0] == '0;
    special = ea == EMAX || eb == EMAX;
    spec_res = nan_a || nan_b || (inf_a && inf_b && sa != sb) ? QNAN : {inf_a ? sa : sb, EMAX, 23'b0};
    sum = same ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
  end
  // sequencer: capture, align, add, normalise one bit per cycle, publish result in FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.ovf <= 1'b0;
      bus.unf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          ra <= bus.a;
          rb <= bus.b;
          rsub <= bus.op_sub;
          bus.ovf <= 1'b0;
          bus.unf <= 1'b0;
          bus.busy <= 1'b1;
          state <= ALIGN;
        end
        ALIGN: if (special) begin
          bus.result <= spec_res;
          bus.done <= 1'b1;
          state <= FINISH;
        end else begin
          ex <= ex_n;
          mx <= mx_n;
          my <= my_n;
          sx <= a_ge ? sa : sb;
          same <= sa == sb;
          state <= ADD;
        end
        ADD: if (sum == '0) begin
          bus.result <= '0;
          bus.done <= 1'b1;
          state <= FINISH;
        end else if (sum[MAN_W]) begin
          bus.result <= ex == EMAX - 1'b1 ? {sx, EMAX, 23'b0} : {sx, ex + 1'b1, sum[MAN_W-1:1]};
          bus.ovf <= ex == EMAX - 1'b1;
          bus.done <= 1'b1;
          state <= FINISH;
        end else if (sum[MAN_W-1]) begin
          bus.result <= {sx, ex, sum[MAN_W-2:0]};
          bus.done <= 1'b1;
          state <= FINISH;
        end else begin
          s <= sum[MAN_W-1:0];
          state <= NORM;
        end
        NORM: if (ex == EXP_W'(1)) begin
          bus.result <= {sx, 31'b0};
          bus.unf <= 1'b1;
          bus.done <= 1'b1;
          state <= FINISH;
        end else begin
          s <= s << 1;
          ex <= ex - 1'b1;
          if (s[MAN_W-2]) begin
            bus.result <= {sx, ex - 1'b1, s[MAN_W-3:0], 1'b0};
            bus.done <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed and random add/sub against an integer-arithmetic reference
module tb_fp_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0;
  int nerr = 0;
  fp_add_seq_if bus();
  fp_add_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output logic o, output logic u, output int lat);
    int ea, eb, ma, mb, ex, ey, mx, my, dd, sm, lz;
    logic sa, sbe, sg, nan, ia, ib;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sbe = b[31] ^ sub;
    o = 1'b0;
    u = 1'b0;
    if (ea == 255 || eb == 255) begin
      ia = ea == 255 && a[22:0] == 0;
      ib = eb == 255 && b[22:0] == 0;
      nan = (ea == 255 && !ia) || (eb == 255 && !ib) || (ia && ib && sa != sbe);
      r = nan ? 32'h7FC00000 : {ia ? sa : sbe, 8'hFF, 23'b0};
      lat = 2;
      return;
    end
    ma = ea == 0 ? 0 : (1 << 23) + int'(a[22:0]);
    mb = eb == 0 ? 0 : (1 << 23) + int'(b[22:0]);
    if (ea * (1 << 23) + (ma & 32'h7FFFFF) >= eb * (1 << 23) + (mb & 32'h7FFFFF)) begin
      ex = ea; ey = eb; mx = ma; my = mb; sg = sa;
    end else begin
      ex = eb; ey = ea; mx = mb; my = ma; sg = sbe;
    end
    dd = ex - ey;
    my = dd >= 25 ? 0 : my >> dd;
    sm = sa == sbe ? mx + my : mx - my;
    lat = 3;
    if (sm == 0) r = 32'h0;
    else if (sm >= (1 << 24)) begin
      sm = sm >> 1;
      ex = ex + 1;
      o = ex == 255;
      r = o ? {sg, 8'hFF, 23'b0} : {sg, 8'(ex), 23'(sm)};
    end else begin
      lz = 0;
      while (sm < (1 << 23)) begin
        sm = sm << 1;
        lz++;
      end
      if (lz >= ex) begin
        u = 1'b1;
        r = {sg, 31'b0};
        lat = 3 + ex;
      end else begin
        r = {sg, 8'(ex - lz), 23'(sm)};
        lat = 3 + lz;
      end
    end
  endfunction
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input int mode);
    logic [31:0] r;
    logic o, u, got;
    int lat, cyc;
    model(a, b, sub, r, o, u, lat);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.op_sub = sub;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        bus.start = cyc == 1;
        if (cyc == 1) begin
          bus.a = $urandom;
          bus.b = $urandom;
          bus.op_sub = ~sub;
        end
      end
      got = bus.done;
    end
    if (!got) begin
      check("timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("result", bus.result, r);
    check("ovf", 32'(bus.ovf), 32'(o));
    check("unf", 32'(bus.unf), 32'(u));
    check("busy_at_done", 32'(bus.busy), 32'd1);
    if (mode == 2) begin
      bus.a = 32'h40400000;
      bus.b = 32'h40400000;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    if (mode != 0) check("result_held", bus.result, r);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op_sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {30'd0, bus.ovf, bus.unf}, 32'd0);
    rst = 1'b0;
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 0);
    run_op(32'h3FC00000, 32'h3F800000, 1'b1, 0);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 0);
    run_op(32'h3F800000, 32'h30800000, 1'b0, 0);
    run_op(32'h7F800000, 32'hFF800000, 1'b0, 0);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0);
    run_op(32'h00800000, 32'h00800001, 1'b1, 0);
    run_op(32'h3F800001, 32'h3F800000, 1'b1, 0);
    run_op(32'h00000000, 32'hC0A00000, 1'b0, 0);
    run_op(32'h7FC00001, 32'h3F800000, 1'b0, 0);
    run_op(32'hFF800000, 32'h3F800000, 1'b1, 0);
    run_op(32'h40490FDB, 32'h3F800000, 1'b0, 1);
    run_op(32'h7F800000, 32'h00000000, 1'b0, 1);
    run_op(32'hC1200000, 32'h40A00000, 1'b0, 2);
    @(negedge clk);
    bus.a = 32'h3F800001;
    bus.b = 32'h3F800000;
    bus.op_sub = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_mid_norm", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", bus.result, 32'd0);
    repeat (25) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op(32'h40000000, 32'h3F800000, 1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      int m;
      a = $urandom;
      m = $urandom_range(0, 3);
      if (m == 0) b = $urandom;
      else if (m == 1) b = a ^ ($urandom & 32'h000000FF);
      else if (m == 2) b = {1'($urandom), 8'(int'(a[30:23]) + $urandom_range(0, 30) - 15), 23'($urandom)};
      else begin
        b = ($urandom_range(0, 1) == 1) ? {1'($urandom), 8'hFF, 23'($urandom_range(0, 1))} : {1'($urandom), 8'h00, 23'($urandom)};
        if ($urandom_range(0, 1) == 1) a[30:23] = 8'hFE;
      end
      run_op(a, b, 1'($urandom), 0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
